// File: rtl/single_port_ram_ctrl_pkg.sv
// Shared definitions for the single_port_ram front-end: RAM tree limits,
// request kind encoding and the pointer-width helper.
package spram_defs;

    // Same limits the single_port_ram hard-block tree is built with.
    localparam int unsigned MEM_MAXADDR = 11;
    localparam int unsigned MEM_MAXDATA = 36;

    // Request kind as carried on req_we.
    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_e;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/spram_rsp_fifo.sv
// Response FIFO for read data returning from the RAM. Power-of-two depth,
// wrapping pointers. dout shows the head and holds its last value when empty.
module spram_rsp_fifo
    import spram_defs::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [clog2(DEPTH):0]  count,
    output logic                   empty
);

    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] hold;
    logic             pop_eff;

    assign empty   = (count == '0);
    // Popping an empty FIFO is a no-op.
    assign pop_eff = pop & ~empty;
    // Storage is never cleared, so the hold register masks stale slots while empty.
    assign dout    = empty ? hold : mem[rd_ptr];

    // Data storage: written on push, no reset needed.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the last-shown output value.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop_eff);
            hold  <= dout;
        end
    end

endmodule

// File: rtl/single_port_ram_ctrl.sv
// Initiator front-end for the single_port_ram tree: turns a valid/ready
// request stream into raw RAM pins and returns read data in order through a
// credit-limited response FIFO.
module single_port_ram_ctrl
    import spram_defs::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_out
);

    localparam int unsigned CW = clog2(RSP_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(RSP_DEPTH);

    req_kind_e   kind;
    logic        fire;
    logic        pop;
    logic        rd_pend;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0] occ;

    assign kind = req_kind_e'(req_we);

    assign rsp_valid = ~fifo_empty;
    assign pop       = rsp_valid & rsp_ready;

    // Occupancy counts the read still in the RAM register, so a FIFO slot is
    // always reserved before the read is issued.
    assign occ       = {1'b0, fifo_count} + (CW + 1)'(rd_pend);
    // Writes share the credit gate so requests never overtake each other.
    assign req_ready = ~reset & ((occ < DEPTH_LIM) | pop);
    assign fire      = req_valid & req_ready;

    assign ram_we   = fire & (kind == REQ_WRITE) & ~reset;
    assign ram_addr = req_addr;
    assign ram_data = req_data;

    // Marks the cycle in which ram_out carries data for an accepted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= fire & (kind == REQ_READ);
        end
    end

    spram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_pend),
        .pop   (pop),
        .din   (ram_out),
        .dout  (rsp_data),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule
